// File: rtl/gate_bist_checker.sv
// Power-on self-test engine for the two-input gate block: drives {a,b} through
// patterns 0..3, samples y after a settle time and records pass/fail results.
module gate_bist_checker #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [27:0] EXP_TABLE     = 28'b0100011_0010110_1010110_1101100,
  parameter int          CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [1:0] first_fail_pat,
  output logic [6:0] first_fail_obs
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       pat;
  logic [CNT_W-1:0] cnt;
  logic             first_seen;
  logic [6:0]       exp_y;
  logic             mismatch;
  logic [2:0]       err_next;
  logic             start_acc;
  logic             settle_last;

  // start is a single-cycle request, accepted only in IDLE or DONE; there is
  // no acknowledge beyond busy rising on the following cycle.
  assign start_acc   = start && (state_q == IDLE || state_q == DONE);
  assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));

  always_comb begin
    exp_y    = EXP_TABLE[7*int'(pat) +: 7];
    mismatch = (y != exp_y);
    err_next = err_count + (mismatch ? 3'd1 : 3'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = CHECK;
      CHECK:   state_d = (pat == 2'd3) ? DONE : SETTLE;
      DONE:    if (start_acc) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q == SETTLE) || (state_q == CHECK);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat            <= 2'd0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 3'd0;
      fail_mask      <= 4'd0;
      first_fail_pat <= 2'd0;
      first_fail_obs <= 7'd0;
      first_seen     <= 1'b0;
    end else if (start_acc) begin
      pat            <= 2'd0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 3'd0;
      fail_mask      <= 4'd0;
      first_fail_pat <= 2'd0;
      first_fail_obs <= 7'd0;
      first_seen     <= 1'b0;
    end else if (state_q == SETTLE) begin
      cnt <= cnt + 1'b1;
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        err_count      <= err_next;
        fail_mask[pat] <= 1'b1;
        if (!first_seen) begin
          first_seen     <= 1'b1;
          first_fail_pat <= pat;
          first_fail_obs <= y;
        end
      end
      // pass must reflect the last pattern too, so it uses the updated count
      if (pat == 2'd3) begin
        pass <= (err_next == 3'd0);
      end else begin
        pat      <= pat + 2'd1;
        {a, b}   <= pat + 2'd1;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: behavioural gate model with injectable faults,
// result scoreboard, timing and sequence checks, plus a SETTLE_CYCLES=1 instance.
module tb_gate_bist_checker;

  localparam int W = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fault_mode = 0;

  logic [W-1:0] exp_q[$];

  // default instance
  logic       start = 1'b0;
  logic       a, b, busy, done, pass;
  logic [6:0] y, first_fail_obs;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [1:0] first_fail_pat;

  // SETTLE_CYCLES=1 instance
  logic       start1 = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] y1, ffo1;
  logic [2:0] err1;
  logic [3:0] mask1;
  logic [1:0] ffp1;

  always #5 clk = ~clk;

  function automatic logic [6:0] gate(input logic ga, input logic gb, input int fault);
    logic [6:0] g;
    g = {~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
    if (fault == 1) g[0] = 1'b0;
    if (fault == 2) g[6] = ~g[6];
    return g;
  endfunction

  always_comb y  = gate(a, b, fault_mode);
  always_comb y1 = gate(a1, b1, 0);

  gate_bist_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_mask(fail_mask), .first_fail_pat(first_fail_pat),
    .first_fail_obs(first_fail_obs)
  );

  gate_bist_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_mask(mask1), .first_fail_pat(ffp1), .first_fail_obs(ffo1)
  );

  function automatic logic [W-1:0] model(input int fault);
    logic [2:0] e;
    logic [3:0] m;
    logic [1:0] fp;
    logic [6:0] fo, obs, gold;
    logic       seen;
    e = 0; m = 0; fp = 0; fo = 0; seen = 0;
    for (int p = 0; p < 4; p++) begin
      gold = gate(p[1], p[0], 0);
      obs  = gate(p[1], p[0], fault);
      if (obs !== gold) begin
        e = e + 3'd1;
        m[p] = 1'b1;
        if (!seen) begin
          seen = 1'b1;
          fp = 2'(p);
          fo = obs;
        end
      end
    end
    return {(e == 3'd0), e, m, fp, fo};
  endfunction

  task automatic start_run(input int fault);
    fault_mode = fault;
    exp_q.push_back(model(fault));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || {a, b} !== 2'b00 || err_count !== 3'd0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b done=%b ab=%b err=%0d, need 1 0 00 0",
               busy, done, {a, b}, err_count);
    end
  endtask

  // Waits for done, optionally checking the {a,b} sequence and pulsing start at
  // cycle poke, then compares the latency and scoreboard entry.
  task automatic wait_done(input int exp_cycles, input bit check_seq, input int poke);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    int c;
    c = 0;
    while (done !== 1'b1 && c < 100) begin
      if (check_seq) begin
        n_cmp++;
        if ({a, b} !== 2'(c / 5) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ab_seq: cycle %0d ab=%b busy=%b, need ab=%0d busy=1", c, {a, b}, busy, c / 5);
        end
      end
      start = (c == poke);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    n_cmp++;
    if (c != exp_cycles || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_latency: done after %0d cycles busy=%b, need %0d busy=0", c, busy, exp_cycles);
    end
    got = {pass, err_count, fail_mask, first_fail_pat, first_fail_obs};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: result with empty expected queue, got %h", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL result: pass=%b err=%0d mask=%b fpat=%0d fobs=%h, need pass=%b err=%0d mask=%b fpat=%0d fobs=%h",
                 got[16], got[15:13], got[12:9], got[8:7], got[6:0],
                 exp[16], exp[15:13], exp[12:9], exp[8:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a, b, busy, done, pass, err_count, fail_mask, first_fail_pat, first_fail_obs} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: ab=%b busy=%b done=%b pass=%b err=%0d mask=%b fp=%0d fo=%h, need all 0",
               {a, b}, busy, done, pass, err_count, fail_mask, first_fail_pat, first_fail_obs);
    end
    n_cmp++;
    if ({a1, b1, busy1, done1, pass1, err1} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state1: ab=%b busy=%b done=%b pass=%b err=%0d, need all 0",
               {a1, b1}, busy1, done1, pass1, err1);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_good;
    start_run(0);
    wait_done(20, 1'b1, -1);
    n_cmp++;
    if ({a, b} !== 2'b11 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL good_hold: ab=%b pass=%b, need 11 1", {a, b}, pass);
    end
  endtask

  task automatic test_stuck_y0;
    start_run(1);
    wait_done(20, 1'b1, -1);
  endtask

  task automatic test_multi_fault;
    start_run(2);
    wait_done(20, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || err_count !== 3'd4 || {a, b} !== 2'b11) begin
      n_fail++;
      $display("FAIL done_hold: done=%b err=%0d ab=%b, need 1 4 11", done, err_count, {a, b});
    end
  endtask

  task automatic test_restart_ignore;
    start_run(2);
    wait_done(20, 1'b1, 7);
    start_run(0);
    n_cmp++;
    if (fail_mask !== 4'd0 || first_fail_obs !== 7'd0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: mask=%b fobs=%h pass=%b, need 0000 00 0", fail_mask, first_fail_obs, pass);
    end
    wait_done(20, 1'b1, -1);
  endtask

  task automatic test_reset_mid_run;
    start_run(2);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if ({a, b} !== 2'b10 || err_count !== 3'd2) begin
      n_fail++;
      $display("FAIL pre_reset: ab=%b err=%0d, need 10 2", {a, b}, err_count);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a, b} !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || err_count !== 3'd0 || fail_mask !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ab=%b busy=%b done=%b err=%0d mask=%b, need 00 0 0 0 0000",
               {a, b}, busy, done, err_count, fail_mask);
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    start_run(0);
    wait_done(20, 1'b1, -1);
  endtask

  task automatic test_settle_one;
    int c;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    c = 0;
    while (done1 !== 1'b1 && c < 100) begin
      n_cmp++;
      if ({a1, b1} !== 2'(c / 2) || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL s1_seq: cycle %0d ab=%b busy=%b, need ab=%0d busy=1", c, {a1, b1}, busy1, c / 2);
      end
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (c != 8 || pass1 !== 1'b1 || err1 !== 3'd0 || mask1 !== 4'd0) begin
      n_fail++;
      $display("FAIL s1_result: cycles=%0d pass=%b err=%0d mask=%b, need 8 1 0 0000", c, pass1, err1, mask1);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck_y0();
    test_multi_fault();
    test_restart_ignore();
    test_reset_mid_run();
    test_settle_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Self-checking stimulus/response engine for the two-input gate block (outputs y0..y6).
- Drives the gate block's {a,b} inputs through all four patterns in order 0..3. After a programmable settle time it samples the seven outputs and compares them against an expected truth table.
- Reports pass/fail, an error count, a per-pattern fail mask and the first failing observation.
- This is the on-chip counterpart to the software stimulus loop, used for power-on self-test of the gate block.

Parameters:
- SETTLE_CYCLES, 4: cycles each pattern is held before sampling; legal range >=1.
- EXP_TABLE, 28'b0100011_0010110_1010110_1101100: expected {y6..y0} per pattern. Bits [7*i+6:7*i] hold pattern i, where i={a,b}.
  - Default encodes y0=AND, y1=OR, y2=NAND, y3=NOR, y4=XOR, y5=XNOR, y6=~a.
  - Default values: pattern 0=0x6C, 1=0x56, 2=0x16, 3=0x23.
- CNT_W, 8: width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a test; ignored while busy=1.
- a  out  1  stimulus to the gate block, registered.
- b  out  1  stimulus to the gate block, registered.
- y  in  7  observed gate outputs {y6..y0}.
- busy  out  1  high while a test is running (SETTLE or CHECK state).
- done  out  1  high from test completion until the next accepted start.
- pass  out  1  valid while done=1; 1 when err_count==0.
- err_count  out  3  number of failing patterns, 0..4.
- fail_mask  out  4  bit i set when pattern i mismatched.
- first_fail_pat  out  2  index of the first failing pattern.
- first_fail_obs  out  7  y value sampled at the first failure.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - a=0, b=0, busy=0, done=0, pass=0.
  - err_count=0, fail_mask=0, first_fail_pat=0, first_fail_obs=0.
  - Internal pattern index and settle counter = 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE, start=1 at edge k:
  - pat=0, {a,b}=2'b00, cnt=0, busy=1, done=0, pass=0.
  - err_count, fail_mask, first_fail_* and the first-fail flag are cleared.
  - Next state is SETTLE.
- SETTLE:
  - cnt increments each cycle; {a,b} is held at pat.
  - When cnt==SETTLE_CYCLES-1, next state is CHECK.
- CHECK (exactly one cycle):
  - y is compared with EXP_TABLE[7*pat +: 7].
  - On mismatch: err_count+1 and fail_mask[pat]=1. If this is the first mismatch of the run, first_fail_pat=pat and first_fail_obs=y.
  - If pat==3: next state DONE, busy=0, done=1, pass=(final err_count==0). The pass value must include the current pattern's result.
  - Otherwise: pat+1, {a,b}=pat+1 registered on the same edge, cnt=0, next state SETTLE.
- Timing:
  - Each pattern occupies SETTLE_CYCLES+1 cycles.
  - done rises at edge k+4*(SETTLE_CYCLES+1); this is 20 cycles for the default.
  - y is sampled exactly SETTLE_CYCLES cycles after {a,b} changes.
- DONE:
  - All results and {a,b}=2'b11 are held until the next start or reset.
  - start in DONE restarts the test identically to IDLE.
- start while busy: ignored, with no effect on state or results.
- y is treated as asynchronous to the test only through the settle time; no synchronizer is included, since the gate block shares clk.
- Reset mid-run: immediate return to the reset values; no partial results are retained.
- err_count never wraps; its maximum is 4.

Test Plan:
- Good DUT: y driven from a behavioural gate model, start pulse -> done=1 at start+20 cycles, pass=1, err_count=0, fail_mask=0000, a/b sequence 00,01,10,11 each held 5 cycles.
- Stuck fault: y0 forced 0 -> only pattern 3 fails; err_count=1, fail_mask=1000, first_fail_pat=3, first_fail_obs=0x22, pass=0.
- Multiple faults: y6 inverted -> err_count=4, fail_mask=1111, first_fail_pat=0, first_fail_obs=0x2C, pass=0.
- Restart and ignore: start pulsed at cycle 7 of a run -> no effect, done still at +20. Second start in DONE -> done drops next cycle, results cleared, new run completes with correct values.
- Reset mid-run: rst_n low during pattern 2 -> immediately a=b=0, busy=0, done=0, err_count=0. A new start afterwards runs a full 20-cycle test.
- Parameter check: SETTLE_CYCLES=1 -> done at start+8 cycles, pass=1 with a good DUT, y sampled 1 cycle after each a/b change.
